// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI peripheral running in the system clock domain. SCLK, MOSI and CS_n
//   are oversampled through 2-flop synchronizers; SCLK and CS_n get a third
//   registered stage for edge detection. Received bytes are assembled
//   MSB-first and presented on o_RX_Byte with a one-cycle o_RX_DV strobe.
//   A one-entry holding register supplies the reply byte shifted out on MISO;
//   DEFAULT_TX is sent whenever the holding register is empty at reload.
//
//   Optional feature macro: SPI_SLAVE_UNDERRUN_EN
//     adds i_Flag_Clr / o_TX_Underrun (sticky flag, set whenever DEFAULT_TX
//     is reloaded because the holding register was empty).
//
// Ports
//   i_Clk, i_Rst_L           system clock, async active-low reset
//   i_SPI_Clk/MOSI/CS_n      SPI inputs from the master (asynchronous)
//   o_SPI_MISO, _En          serial reply and its output enable
//   o_RX_DV, o_RX_Byte       received byte strobe / data
//   i_TX_Byte, i_TX_DV       reply byte load, accepted when o_TX_Ready=1
//   o_TX_Ready               holding register empty
//   o_Busy                   frame in progress
//   o_Byte_Count             complete bytes in the current frame (saturating)
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int unsigned SPI_MODE   = 0,
  parameter logic [7:0]  DEFAULT_TX = 8'hFF,
  parameter int unsigned BYTE_CNT_W = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_MOSI,
  input  logic                  i_SPI_CS_n,
  output logic                  o_SPI_MISO,
  output logic                  o_SPI_MISO_En,
  output logic                  o_RX_DV,
  output logic [7:0]            o_RX_Byte,
  input  logic [7:0]            i_TX_Byte,
  input  logic                  i_TX_DV,
  output logic                  o_TX_Ready,
  output logic                  o_Busy,
  output logic [BYTE_CNT_W-1:0] o_Byte_Count
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  input  logic                  i_Flag_Clr,
  output logic                  o_TX_Underrun
`endif
);

  localparam logic [1:0] MODE = 2'(SPI_MODE);
  localparam logic       CPOL = MODE[1];
  localparam logic       CPHA = MODE[0];

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t     r_state;
  logic [2:0] r_sclk_sync;   // [0],[1] synchronizer, [2] edge-detect copy
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync;
  logic [6:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_tx_shift;
  logic [3:0] r_tx_cnt;      // bits still to present from r_tx_shift
  logic [7:0] r_tx_hold;
  logic       r_tx_full;

  logic       w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic       w_sample, w_shift, w_cs_fall, w_cs_n;
  logic       w_reload;
  logic [7:0] w_tx_load;
  logic [7:0] w_rx_next;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sclk_sync <= {3{CPOL}};
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i_SPI_Clk};
      r_cs_sync   <= {r_cs_sync[1:0], i_SPI_CS_n};
      r_mosi_sync <= {r_mosi_sync[0], i_SPI_MOSI};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = CPHA ? w_trail : w_lead;
  assign w_shift     = CPHA ? w_lead : w_trail;
  assign w_cs_n      = r_cs_sync[1];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];

  assign w_tx_load   = r_tx_full ? r_tx_hold : DEFAULT_TX;
  assign w_rx_next   = {r_rx_shift, r_mosi_sync[1]};

  // Shift register reloads at frame entry and on the shift edge after bit 0.
  assign w_reload = ((r_state == S_IDLE) && w_cs_fall) ||
                    ((r_state == S_ACTIVE) && !w_cs_n && w_shift && (r_tx_cnt == 4'd0));

  assign o_TX_Ready = ~r_tx_full;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state       <= S_IDLE;
      r_rx_shift    <= '0;
      r_bit_cnt     <= '0;
      r_tx_shift    <= '0;
      r_tx_cnt      <= '0;
      r_tx_hold     <= '0;
      r_tx_full     <= 1'b0;
      o_SPI_MISO    <= 1'b0;
      o_SPI_MISO_En <= 1'b0;
      o_RX_DV       <= 1'b0;
      o_RX_Byte     <= '0;
      o_Busy        <= 1'b0;
      o_Byte_Count  <= '0;
    end else begin
      o_RX_DV <= 1'b0;

      // A byte offered on a reload cycle is accepted even when the holding
      // register is full: the reload empties it in the same cycle.
      if (i_TX_DV && (!r_tx_full || w_reload)) begin
        r_tx_hold <= i_TX_Byte;
        r_tx_full <= 1'b1;
      end else if (w_reload) begin
        r_tx_full <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state       <= S_ACTIVE;
            r_bit_cnt     <= '0;
            o_Byte_Count  <= '0;
            o_Busy        <= 1'b1;
            o_SPI_MISO_En <= 1'b1;
            if (CPHA) begin
              // MSB goes out on the first leading edge.
              r_tx_shift <= w_tx_load;
              r_tx_cnt   <= 4'd8;
            end else begin
              o_SPI_MISO <= w_tx_load[7];
              r_tx_shift <= {w_tx_load[6:0], 1'b0};
              r_tx_cnt   <= 4'd7;
            end
          end
        end

        S_ACTIVE: begin
          if (w_cs_n) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            o_Busy        <= 1'b0;
            o_SPI_MISO_En <= 1'b0;
            o_SPI_MISO    <= 1'b0;
          end else begin
            if (w_sample) begin
              r_rx_shift <= w_rx_next[6:0];
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                o_RX_Byte <= w_rx_next;
                o_RX_DV   <= 1'b1;
                if (o_Byte_Count != '1)
                  o_Byte_Count <= o_Byte_Count + BYTE_CNT_W'(1);
              end
            end
            if (w_shift) begin
              if (r_tx_cnt == 4'd0) begin
                o_SPI_MISO <= w_tx_load[7];
                r_tx_shift <= {w_tx_load[6:0], 1'b0};
                r_tx_cnt   <= 4'd7;
              end else begin
                o_SPI_MISO <= r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_tx_cnt   <= r_tx_cnt - 4'd1;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      o_TX_Underrun <= 1'b0;
    else if (w_reload && !r_tx_full)
      o_TX_Underrun <= 1'b1;
    else if (i_Flag_Clr)
      o_TX_Underrun <= 1'b0;
  end
`endif

endmodule
